wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Write-back pipeline stage directly upstream of the 16-entry 4-bit general-purpose register bank.
- Captures each execute-stage result (destination index, data, write-enable) into a one-deep write-back latch.
- Drives the bank's shared write data `d` and one-hot `load[15:0]` for exactly one cycle per write.
- Provides a forwarding path so same-cycle readers see the pending value before the bank updates. Also keeps a retired-write counter for debug.

Parameters:
- NREG, 16, number of registers in the bank; width of `load`.
- AW, 4, register index width (log2 NREG).
- DW, 4, data width.
- CW, 8, width of the retired-write counter.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- ex_valid  input  1  execute stage presents an instruction this cycle.
- ex_we  input  1  that instruction writes a register.
- ex_dest  input  AW  destination register index.
- ex_data  input  DW  result to write.
- stall  input  1  hold the write-back latch; do not accept `ex_*`.
- flush  input  1  discard the incoming `ex_*` this cycle.
- rs_a  input  AW  read index A, for forwarding compare.
- rs_b  input  AW  read index B, for forwarding compare.
- d  output  DW  write data to the register bank.
- load  output  NREG  one-hot write strobe to the register bank.
- fwd_a_hit  output  1  pending write targets `rs_a`.
- fwd_b_hit  output  1  pending write targets `rs_b`.
- fwd_data  output  DW  pending write value (equals `d`).
- wb_count  output  CW  number of writes issued, modulo 2^CW.

Behaviour:
- Reset is asynchronous and active-low. While `reset` = 0:
  - state = EMPTY; latch dest/data = 0; `wb_count` = 0.
  - `load` = 0, `d` = 0, `fwd_a_hit` = `fwd_b_hit` = 0.
- States:
  - EMPTY: no latched write.
  - PEND: latched write being issued this cycle.
  - HELD: write already issued, latch held by stall.
- Accept condition `acc` = `ex_valid` & `ex_we` & !`stall` & !`flush`. Accepting captures `ex_dest` and `ex_data`.
- Transitions, evaluated at each rising edge; `flush` has priority over `stall`:
  - EMPTY: `acc` -> PEND; otherwise stay EMPTY.
  - PEND:
    - `flush` -> EMPTY.
    - `stall` -> HELD.
    - `acc` -> PEND with the new capture (back-to-back writes).
    - otherwise -> EMPTY.
  - HELD:
    - `flush` -> EMPTY.
    - `stall` -> HELD.
    - `acc` -> PEND.
    - otherwise -> EMPTY.
- Outputs in PEND:
  - `load` = 1 << dest; exactly one bit is set.
  - `d` = latched data.
  - The bank captures at the edge ending the PEND cycle.
  - Latency: `ex_*` accepted at edge N -> `load` asserted in cycle N..N+1 -> bank updated at edge N+1.
- Outputs in EMPTY/HELD: `load` = 0. `d` holds the latched value; it is don't-care to the bank but must be deterministic.
- HELD exists so a stalled latch never re-strobes `load`. Exactly one write per accepted instruction.
- A flush arriving during PEND does not cancel the write presented that cycle; that write belongs to an older instruction. Flush only blocks capture of `ex_*`.
- Forwarding:
  - `fwd_a_hit` = (state == PEND) & (dest == `rs_a`); `fwd_b_hit` is the same with `rs_b`. Combinational.
  - In HELD the bank already holds the value, so there is no hit.
- `wb_count` increments by 1 in every PEND cycle and wraps from 2^CW-1 to 0.
- `ex_valid` = 1 with `ex_we` = 0 is never captured (no write, no count).
- Reset asserted mid-PEND forces `load` = 0 immediately (asynchronous); that write is lost.

Decomposition:
- Shared package `cpu_pkg` holds:
  - the state encoding enum `wb_state_t` (EMPTY = 2'b00, PEND = 2'b01, HELD = 2'b10);
  - NREG/AW/DW constants shared with the register bank.
- One natural sub-module, `onehot_dec`: AW-to-NREG decoder with enable, producing `load`.

Test Plan:
- Reset then `ex_valid` = `ex_we` = 1, `ex_dest` = 4'h5, `ex_data` = 4'hA -> next cycle `load` = 16'h0020, `d` = 4'hA, `wb_count` = 0 -> 1 after the edge; following idle cycle `load` = 0.
- Back-to-back writes to dest 3 (data 1) then dest C (data 7) -> `load` = 16'h0008 then 16'h1000 on consecutive cycles; `wb_count` = 2.
- Capture dest 2 (data 9), then hold `stall` = 1 for 3 cycles -> `load` = 16'h0004 for exactly one cycle, then 0 while stalled (HELD); `wb_count` = 1.
- `flush` = 1 with `ex_valid` = `ex_we` = 1, dest 7 -> no `load` next cycle. Also `flush` and `stall` together from HELD -> EMPTY.
- During PEND with dest 6: `rs_a` = 6, `rs_b` = 1 -> `fwd_a_hit` = 1, `fwd_b_hit` = 0, `fwd_data` = latched data. Same indices in HELD -> both hits 0.
- Issue 256 writes -> `wb_count` wraps to 0. Then assert `reset` low mid-PEND -> `load` = 0 within the same cycle, state EMPTY.

Source files
------------

// File: rtl/cpu_pkg.sv
// Constants and state encoding shared between the write-back stage and the
// register bank it feeds.
package cpu_pkg;

  localparam int NREG = 16;  // registers in the bank
  localparam int AW   = 4;   // register index width
  localparam int DW   = 4;   // register data width
  localparam int CW   = 8;   // retired-write counter width

  // Write-back latch occupancy.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,  // nothing latched
    PEND  = 2'b01,  // latched write is being strobed into the bank this cycle
    HELD  = 2'b10   // write already strobed, latch frozen by a stall
  } wb_state_t;

endpackage

// File: rtl/onehot_dec.sv
// Index-to-one-hot decoder with enable; drives the bank's per-register
// write strobes.
module onehot_dec #(
  parameter int AW   = cpu_pkg::AW,
  parameter int NREG = cpu_pkg::NREG
) (
  input  logic            en,
  input  logic [AW-1:0]   idx,
  output logic [NREG-1:0] onehot
);

  // Set exactly the indexed bit when enabled, otherwise all zero.
  always_comb begin
    // NOTE: the all-zero default comes first so every path assigns onehot,
    // which keeps this block purely combinational (no latch).
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: a one-deep latch between execute and the register bank.
// Each accepted write strobes `load` for exactly one cycle, exposes its
// value to same-cycle readers through the forwarding outputs, and bumps a
// wrapping debug counter.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int NREG = cpu_pkg::NREG,
  parameter int AW   = cpu_pkg::AW,
  parameter int DW   = cpu_pkg::DW,
  parameter int CW   = cpu_pkg::CW
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic            ex_we,
  input  logic [AW-1:0]   ex_dest,
  input  logic [DW-1:0]   ex_data,
  input  logic            stall,
  input  logic            flush,
  input  logic [AW-1:0]   rs_a,
  input  logic [AW-1:0]   rs_b,
  output logic [DW-1:0]   d,
  output logic [NREG-1:0] load,
  output logic            fwd_a_hit,
  output logic            fwd_b_hit,
  output logic [DW-1:0]   fwd_data,
  output logic [CW-1:0]   wb_count
);

  wb_state_t     state_q, state_d;
  logic [AW-1:0] dest_q;
  logic [DW-1:0] data_q;
  logic [CW-1:0] count_q;
  logic          acc;
  logic          pend;

  // A new write is taken only when it really writes and nothing blocks it.
  assign acc  = ex_valid & ex_we & ~stall & ~flush;
  assign pend = (state_q == PEND);

  // Next-state selection; flush outranks stall, and a flush during PEND
  // still lets the current (older) write go out this cycle.
  always_comb begin
    state_d = EMPTY;
    unique case (state_q)
      EMPTY: state_d = acc ? PEND : EMPTY;
      PEND, HELD: begin
        if (flush)      state_d = EMPTY;
        else if (stall) state_d = HELD;
        else if (acc)   state_d = PEND;
        else            state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // State register, latch capture and retired-write counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      dest_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      if (acc) begin
        dest_q <= ex_dest;
        data_q <= ex_data;
      end
      if (pend) count_q <= count_q + CW'(1);
    end
  end

  // Strobe generation; only PEND drives a write, so HELD never re-strobes.
  onehot_dec #(
    .AW   (AW),
    .NREG (NREG)
  ) u_dec (
    .en     (pend),
    .idx    (dest_q),
    .onehot (load)
  );

  assign d         = data_q;
  assign fwd_data  = data_q;
  assign fwd_a_hit = pend & (dest_q == rs_a);
  assign fwd_b_hit = pend & (dest_q == rs_b);
  assign wb_count  = count_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: every accepted instruction is expected to produce one
// bank write in the following cycle; a scoreboard queue holds those writes
// and a negedge monitor compares whatever the DUT shows against it.
module tb_wb_stage;
  import cpu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid = 1'b0, ex_we = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [3:0]  ex_dest = '0, ex_data = '0, rs_a = '0, rs_b = '0;
  logic [3:0]  d, fwd_data;
  logic [15:0] load;
  logic        fwd_a_hit, fwd_b_hit;
  logic [7:0]  wb_count;

  wb_stage dut (
    .clock     (clock),
    .reset     (reset),
    .ex_valid  (ex_valid),
    .ex_we     (ex_we),
    .ex_dest   (ex_dest),
    .ex_data   (ex_data),
    .stall     (stall),
    .flush     (flush),
    .rs_a      (rs_a),
    .rs_b      (rs_b),
    .d         (d),
    .load      (load),
    .fwd_a_hit (fwd_a_hit),
    .fwd_b_hit (fwd_b_hit),
    .fwd_data  (fwd_data),
    .wb_count  (wb_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] dest;
    logic [3:0] data;
    int         cyc;
  } wr_t;

  wr_t        exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] exp_count = '0;
  logic [3:0] last_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted instruction becomes one write due next cycle.
  always @(posedge clock) begin
    cyc++;
    if (reset && ex_valid && ex_we && !stall && !flush) begin
      exp_q.push_back('{ex_dest, ex_data, cyc});
      last_data = ex_data;
    end
  end

  // Monitor: compare the DUT against the scoreboard once per cycle.
  always @(negedge clock) begin
    wr_t         w;
    logic [15:0] exp_load;
    if (!reset) begin
      check("rst_load", load, 0);
      check("rst_d", d, 0);
      check("rst_count", wb_count, 0);
      check("rst_hits", {fwd_a_hit, fwd_b_hit}, 0);
    end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      w = exp_q.pop_front();
      exp_load = 16'h1 << w.dest;
      check("wr_load", load, exp_load);
      check("wr_d", d, w.data);
      check("wr_fwd_data", fwd_data, w.data);
      check("wr_hit_a", fwd_a_hit, rs_a == w.dest);
      check("wr_hit_b", fwd_b_hit, rs_b == w.dest);
      check("wr_count", wb_count, exp_count);
      exp_count = exp_count + 8'd1;
    end else begin
      check("idle_load", load, 0);
      check("idle_hits", {fwd_a_hit, fwd_b_hit}, 0);
      check("idle_d", d, last_data);
      check("idle_count", wb_count, exp_count);
    end
  end

  task automatic drive(input logic v, input logic we, input logic [3:0] dst, input logic [3:0] dat,
                       input logic st, input logic fl, input logic [3:0] ra, input logic [3:0] rb);
    ex_valid = v; ex_we = we; ex_dest = dst; ex_data = dat;
    stall = st; flush = fl; rs_a = ra; rs_b = rb;
  endtask

  // Apply inputs for one cycle; returns 1 time unit after the sampling edge.
  task automatic step(input logic v, input logic we, input logic [3:0] dst, input logic [3:0] dat,
                      input logic st, input logic fl, input logic [3:0] ra, input logic [3:0] rb);
    drive(v, we, dst, dat, st, fl, ra, rb);
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    exp_q.delete();
    exp_count = '0;
    last_data = '0;
    idle();
    idle();
    reset = 1'b1;
  endtask

  initial begin
    apply_reset();

    // Single write to r5.
    step(1, 1, 4'h5, 4'hA, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("t1_load", load, 16'h0020);
    check("t1_d", d, 4'hA);
    check("t1_count0", wb_count, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("t1_count1", wb_count, 1);
    check("t1_idle_load", load, 0);

    // Back-to-back writes r3 then rC.
    apply_reset();
    step(1, 1, 4'h3, 4'h1, 0, 0, 0, 0);
    check("t2_load_a", load, 16'h0008);
    step(1, 1, 4'hC, 4'h7, 0, 0, 0, 0);
    check("t2_load_b", load, 16'h1000);
    idle();
    check("t2_count", wb_count, 2);
    check("t2_idle_load", load, 0);

    // Capture r2 then stall three cycles: one strobe only.
    apply_reset();
    step(1, 1, 4'h2, 4'h9, 0, 0, 0, 0);
    check("t3_load", load, 16'h0004);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 4'hF, 4'h3, 1, 0, 0, 0);
      check("t3_held_load", load, 0);
    end
    idle();
    check("t3_count", wb_count, 1);

    // Flush blocks capture; flush+stall from HELD empties the latch.
    apply_reset();
    step(1, 1, 4'h7, 4'h4, 0, 1, 0, 0);
    check("t4_flush_load", load, 0);
    step(1, 1, 4'h1, 4'h2, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    check("t4_fs_load", load, 0);
    idle();
    check("t4_count", wb_count, 1);

    // Forwarding in PEND, none in HELD.
    apply_reset();
    step(1, 1, 4'h6, 4'hD, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 4'h6, 4'h1);
    #1;
    check("t5_hit_a", fwd_a_hit, 1);
    check("t5_hit_b", fwd_b_hit, 0);
    check("t5_fwd_data", fwd_data, 4'hD);
    step(0, 0, 0, 0, 1, 0, 4'h6, 4'h1);
    check("t5_held_hits", {fwd_a_hit, fwd_b_hit}, 0);
    step(0, 0, 0, 0, 1, 0, 4'h6, 4'h1);
    idle();

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    idle();

    // 256 writes wrap the counter.
    apply_reset();
    for (int i = 0; i < 256; i++)
      step(1, 1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0, 0, 0, 0);
    idle();
    check("t6_wrap", wb_count, 0);

    // Reset in the middle of a PEND cycle kills the strobe at once.
    step(1, 1, 4'h9, 4'h3, 0, 0, 0, 0);
    check("t7_pre_load", load, 16'h0200);
    reset = 1'b0;
    exp_q.delete();
    exp_count = '0;
    last_data = '0;
    #1;
    check("t7_load", load, 0);
    check("t7_d", d, 0);
    check("t7_count", wb_count, 0);
    idle();
    reset = 1'b1;
    idle();
    check("t7_after_load", load, 0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
